seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_pkg.sv | 7 +
 rtl/seg7_dwell_timer.sv | 19 +
 rtl/seg7_scan_ctrl.sv | 113 +++++++++++
 tb/tb_seg7_scan_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg: scan-controller state encoding and parameter defaults
package seg7_scan_pkg;
    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
    localparam int DEF_N_DIGITS = 4;
    localparam int DEF_DWELL    = 1000;
    localparam int DEF_GAP_CYC  = 2;
endpackage

// File: rtl/seg7_dwell_timer.sv
// seg7_dwell_timer: loadable down-counter with terminal-count flag and look-ahead value
module seg7_dwell_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          ld,
    input  logic [CW-1:0] ld_val,
    output logic [CW-1:0] cnt_nxt,
    output logic          tc
);
    logic [CW-1:0] cnt;
    always_comb cnt_nxt = clr ? '0 : ld ? ld_val : (cnt != '0) ? cnt - 1'b1 : cnt;
    always_ff @(posedge clk)
        if (rst) cnt <= '0;
        else     cnt <= cnt_nxt;
    assign tc = (cnt == '0);
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed BCD digit scanner driving an external 7-segment decoder
module seg7_scan_ctrl
    import seg7_scan_pkg::*;
#(
    parameter int N_DIGITS = DEF_N_DIGITS,
    parameter int DWELL    = DEF_DWELL,
    parameter int GAP_CYC  = DEF_GAP_CYC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic                  load,
    output logic                  load_ack,
    input  logic                  lz_en,
    input  logic                  lamp_test,
    output logic [3:0]            seg_bcd,
    output logic                  seg_lt_n,
    output logic                  seg_rbi_n,
    output logic                  seg_bi_n,
    output logic [N_DIGITS-1:0]   digit_an_n,
    output logic                  frame_done
);
    localparam int MAXC = (DWELL > GAP_CYC) ? DWELL : GAP_CYC;
    localparam int CW   = $clog2(MAXC);
    localparam int KW   = $clog2(N_DIGITS);

    state_t                state, state_n;
    logic [KW-1:0]         k, k_n;
    logic [4*N_DIGITS-1:0] shadow, display, disp_n;
    logic                  pending, zrun, zrun_n, commit, frame_start, ld, tc, show;
    logic [CW-1:0]         ld_val, cnt_nxt;
    logic [3:0]            nib_cur, bcd_o;
    logic [N_DIGITS-1:0]   an_o;
    logic                  rbi_o, ack_o, fd_o;

    seg7_dwell_timer #(.CW(CW)) u_timer (
        .clk(clk), .rst(rst), .clr(!en), .ld(ld), .ld_val(ld_val), .cnt_nxt(cnt_nxt), .tc(tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            shadow     <= '0;
            display    <= '0;
            pending    <= 1'b0;
            zrun       <= 1'b0;
            seg_bcd    <= 4'h0;
            seg_lt_n   <= 1'b1;
            seg_rbi_n  <= 1'b1;
            seg_bi_n   <= 1'b0;
            digit_an_n <= '1;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            k          <= k_n;
            shadow     <= load ? bcd_in : shadow;
            display    <= disp_n;
            // a load on the commit edge re-arms pending so it lands next frame
            pending    <= load | (pending & ~commit);
            zrun       <= zrun_n;
            seg_bcd    <= bcd_o;
            seg_lt_n   <= ~lamp_test;
            seg_rbi_n  <= rbi_o;
            seg_bi_n   <= show;
            digit_an_n <= an_o;
            load_ack   <= ack_o;
            frame_done <= fd_o;
        end
    end

    always_comb begin
        state_n     = state;
        k_n         = k;
        ld          = 1'b0;
        ld_val      = CW'(DWELL - 1);
        frame_start = 1'b0;
        if (!en) begin
            state_n = IDLE;
            k_n     = '0;
        end else if (state == IDLE) begin
            state_n     = SHOW;
            k_n         = KW'(N_DIGITS - 1);
            ld          = 1'b1;
            frame_start = 1'b1;
        end else if (tc) begin
            ld = 1'b1;
            if (state == SHOW) begin
                state_n = GAP;
                ld_val  = CW'(GAP_CYC - 1);
            end else begin
                state_n     = SHOW;
                k_n         = (k == '0) ? KW'(N_DIGITS - 1) : k - 1'b1;
                frame_start = (k == '0);
            end
        end
    end

    always_comb begin
        commit  = frame_start & pending;
        disp_n  = commit ? shadow : display;
        nib_cur = display[4*k +: 4];
        zrun_n  = frame_start ? lz_en : (state == SHOW && state_n == GAP) ? zrun && (nib_cur == 4'h0) : zrun;
        show    = (state_n == SHOW);
        an_o    = show ? ~(N_DIGITS'(1) << k_n) : '1;
        bcd_o   = show ? disp_n[4*k_n +: 4] : 4'h0;
        rbi_o   = ~(show && zrun_n && k_n != '0);
        ack_o   = commit;
        fd_o    = (state_n == GAP) && (k_n == '0) && (cnt_nxt == '0);
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed table-driven bench for seg7_scan_ctrl (4 digits, DWELL=4, GAP_CYC=1)
module tb_seg7_scan_ctrl;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, load = 1'b0, lz_en = 1'b0, lamp_test = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        load_ack, seg_lt_n, seg_rbi_n, seg_bi_n, frame_done;
    logic [3:0]  seg_bcd, digit_an_n;
    logic        lt_exp = 1'b1;
    int          total = 0, passed = 0;

    typedef struct {
        logic        lz;
        logic [15:0] val;
        logic [3:0]  rbi;
    } vec_t;
    vec_t tbl[7];

    seg7_scan_ctrl #(.N_DIGITS(4), .DWELL(4), .GAP_CYC(1)) dut (
        .clk(clk), .rst(rst), .en(en), .bcd_in(bcd_in), .load(load), .load_ack(load_ack),
        .lz_en(lz_en), .lamp_test(lamp_test), .seg_bcd(seg_bcd), .seg_lt_n(seg_lt_n),
        .seg_rbi_n(seg_rbi_n), .seg_bi_n(seg_bi_n), .digit_an_n(digit_an_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " an_n"}, 32'(digit_an_n), 32'hF);
        chk({tag, " bcd"}, 32'(seg_bcd), 32'h0);
        chk({tag, " lt_n"}, 32'(seg_lt_n), 32'h1);
        chk({tag, " rbi_n"}, 32'(seg_rbi_n), 32'h1);
        chk({tag, " bi_n"}, 32'(seg_bi_n), 32'h0);
        chk({tag, " ack"}, 32'(load_ack), 32'h0);
        chk({tag, " fd"}, 32'(frame_done), 32'h0);
    endtask

    // One full 20-cycle frame starting at its first SHOW cycle; optional loads at cycles 5 and 12,
    // optional lamp test over cycles 2..9.
    task automatic run_frame(input logic [15:0] val, input logic [3:0] rbi, input logic ack_e,
                             input int nld, input logic [15:0] l1, input logic [15:0] l2,
                             input logic nlz, input logic lt);
        logic [3:0] an_e;
        logic       nxt;
        int         d, w;
        for (int c = 0; c < 20; c++) begin
            d    = 3 - c / 5;
            w    = c % 5;
            an_e = 4'hF;
            if (w < 4) an_e[d] = 1'b0;
            chk($sformatf("v%04h c%0d an_n", val, c), 32'(digit_an_n), 32'(an_e));
            chk($sformatf("v%04h c%0d bi_n", val, c), 32'(seg_bi_n), 32'(w < 4));
            if (w < 4) begin
                chk($sformatf("v%04h c%0d bcd", val, c), 32'(seg_bcd), 32'(val[4*d +: 4]));
                chk($sformatf("v%04h c%0d rbi_n", val, c), 32'(seg_rbi_n), 32'(rbi[d]));
            end
            chk($sformatf("v%04h c%0d fd", val, c), 32'(frame_done), 32'(c == 19));
            chk($sformatf("v%04h c%0d ack", val, c), 32'(load_ack), 32'(ack_e && c == 0));
            chk($sformatf("v%04h c%0d lt_n", val, c), 32'(seg_lt_n), 32'(lt_exp));
            load = 1'b0;
            if (c == 5) begin
                lz_en = nlz;
                if (nld >= 1) begin load = 1'b1; bcd_in = l1; end
            end
            if (c == 12 && nld >= 2) begin load = 1'b1; bcd_in = l2; end
            if (c == 2) lamp_test = lt;
            if (c == 10) lamp_test = 1'b0;
            nxt = ~lamp_test;
            tick();
            lt_exp = nxt;
        end
        load = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b0, 16'h1234, 4'b1111};
        tbl[1] = '{1'b1, 16'h0070, 4'b0001};
        tbl[2] = '{1'b1, 16'h0000, 4'b0001};
        tbl[3] = '{1'b0, 16'h0000, 4'b1111};
        tbl[4] = '{1'b1, 16'h1000, 4'b0111};
        tbl[5] = '{1'b1, 16'h00AB, 4'b0001};
        tbl[6] = '{1'b1, 16'h0F05, 4'b0011};

        lamp_test = 1'b1;
        tick();
        tick();
        chk_reset("reset");
        rst       = 1'b0;
        lamp_test = 1'b0;
        lz_en     = tbl[0].lz;
        load      = 1'b1;
        bcd_in    = tbl[0].val;
        tick();
        load = 1'b0;
        chk("idle an_n", 32'(digit_an_n), 32'hF);
        chk("idle bi_n", 32'(seg_bi_n), 32'h0);
        en = 1'b1;
        tick();
        lt_exp = 1'b1;

        for (int i = 0; i < 7; i++)
            if (i < 6) run_frame(tbl[i].val, tbl[i].rbi, 1'b1, 1, tbl[i+1].val, 16'h0, tbl[i+1].lz, 1'b0);
            else       run_frame(tbl[i].val, tbl[i].rbi, 1'b1, 2, 16'h5678, 16'h9ABC, 1'b0, 1'b0);
        run_frame(16'h9ABC, 4'hF, 1'b1, 0, 16'h0, 16'h0, 1'b0, 1'b1);
        run_frame(16'h9ABC, 4'hF, 1'b0, 0, 16'h0, 16'h0, 1'b0, 1'b0);

        for (int c = 0; c < 4; c++) tick();
        chk("gap an_n", 32'(digit_an_n), 32'hF);
        en = 1'b0;
        tick();
        chk("en0 an_n", 32'(digit_an_n), 32'hF);
        chk("en0 bi_n", 32'(seg_bi_n), 32'h0);
        chk("en0 fd", 32'(frame_done), 32'h0);
        tick();
        chk("en0 hold an_n", 32'(digit_an_n), 32'hF);
        en = 1'b1;
        tick();
        run_frame(16'h9ABC, 4'hF, 1'b0, 0, 16'h0, 16'h0, 1'b0, 1'b0);

        for (int c = 0; c < 11; c++) tick();
        chk("d1 an_n", 32'(digit_an_n), 32'hD);
        rst       = 1'b1;
        load      = 1'b1;
        bcd_in    = 16'h4321;
        lamp_test = 1'b1;
        tick();
        chk_reset("midrst");
        rst       = 1'b0;
        load      = 1'b0;
        lamp_test = 1'b0;
        tick();
        lt_exp = 1'b1;
        run_frame(16'h0000, 4'hF, 1'b0, 0, 16'h0, 16'h0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
